ret_addr_stack: RTL and testbench

Return-address stack (RAS) for the front-end branch predictor. The decode/commit side pushes the link address when it sees a call (JAL/JALR with rd = ra). It pops when it sees a return (JALR rs1 = ra, rd = x0). The fetch side reads the current top-of-stack as the predicted return target. The block keeps a checkpointable TOS pointer and count so that a branch misprediction can roll the stack back in one cycle.

---
 rtl/ret_addr_stack_pkg.sv | 13 +
 rtl/ret_addr_stack_if.sv | 38 +++
 rtl/ret_addr_stack_ras_regfile.sv | 31 +++
 rtl/ret_addr_stack.sv | 99 +++++++++
 tb/tb_ret_addr_stack.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ret_addr_stack_pkg.sv
// Shared constants and types for the return-address stack.
package ret_addr_stack_pkg;

   localparam int RET_STACK_SIZE        = 16;
   localparam int RET_PRED_POINTER_SIZE = 4;

   // Predicted target reported while the stack is empty.
   localparam logic [31:0] kernel_adr = 32'hF0000000;

   typedef logic [RET_PRED_POINTER_SIZE-1:0] ras_ptr_t;
   typedef logic [RET_PRED_POINTER_SIZE:0]   ras_cnt_t;

endpackage

// File: rtl/ret_addr_stack_if.sv
// Request/prediction bundle between the decode/fetch front end and the RAS.
//
// Handshake: there is no valid/ready pair. push_i, pop_i and restore_i are
// single-cycle strobes that the stack accepts unconditionally in the cycle
// they are high; the tos/count/pred outputs always reflect the registered
// state, and overflow_o/underflow_o are one-cycle registered pulses.
interface ret_addr_stack_if
   import ret_addr_stack_pkg::*;
#(
   parameter int PTR_W = RET_PRED_POINTER_SIZE
) ();

   logic             push_i;
   logic [31:0]      push_adr_i;
   logic             pop_i;
   logic             restore_i;
   logic [PTR_W-1:0] restore_ptr_i;
   logic [PTR_W:0]   restore_cnt_i;
   logic [PTR_W-1:0] tos_ptr_o;
   logic [PTR_W:0]   count_o;
   logic             pred_valid_o;
   logic [31:0]      pred_adr_o;
   logic             overflow_o;
   logic             underflow_o;

   // Front end: issues requests, consumes the prediction.
   modport master (
      output push_i, push_adr_i, pop_i, restore_i, restore_ptr_i, restore_cnt_i,
      input  tos_ptr_o, count_o, pred_valid_o, pred_adr_o, overflow_o, underflow_o
   );

   // The stack itself.
   modport slave (
      input  push_i, push_adr_i, pop_i, restore_i, restore_ptr_i, restore_cnt_i,
      output tos_ptr_o, count_o, pred_valid_o, pred_adr_o, overflow_o, underflow_o
   );

endinterface

// File: rtl/ret_addr_stack_ras_regfile.sv
// DEPTH x 32 entry array: one synchronous write port, one combinational read
// port, synchronous active-low clear of every entry.
module ras_regfile #(
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Clear all entries on reset, otherwise write one entry when enabled.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/ret_addr_stack.sv
// Return-address stack: circular entry array with checkpointable TOS
// pointer and occupancy, so a misprediction can roll back in one cycle.
module ret_addr_stack
   import ret_addr_stack_pkg::*;
#(
   parameter int DEPTH = RET_STACK_SIZE,
   parameter int PTR_W = RET_PRED_POINTER_SIZE
) (
   input  logic            clk,
   input  logic            reset_n,
   ret_addr_stack_if.slave bus
);

   localparam logic [PTR_W-1:0] TOS_RESET = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);

   logic [PTR_W-1:0] tos;
   logic [PTR_W:0]   cnt;
   logic             overflow;
   logic             underflow;
   logic             empty;
   logic             wr_en;
   logic [PTR_W-1:0] wr_addr;
   logic [31:0]      rd_data;

   assign empty = (cnt == '0);

   // A write happens for any push not shadowed by restore. Push+pop on a
   // non-empty stack replaces the top in place; otherwise the new entry
   // lands one above the current top.
   always_comb begin
      wr_en   = bus.push_i && !bus.restore_i;
      wr_addr = tos + PTR_ONE;
      if (bus.pop_i && !empty) begin
         wr_addr = tos;
      end
   end

   // Pointer, occupancy and pulse registers in priority order:
   // restore > push+pop > push > pop.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tos       <= TOS_RESET;
         cnt       <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
         if (bus.restore_i) begin
            tos <= bus.restore_ptr_i;
            cnt <= bus.restore_cnt_i;
         end else if (bus.push_i && bus.pop_i) begin
            // Replace-top leaves tos/cnt alone; on an empty stack it is a push.
            if (empty) begin
               tos <= tos + PTR_ONE;
               cnt <= CNT_ONE;
            end
         end else if (bus.push_i) begin
            tos <= tos + PTR_ONE;
            if (cnt == CNT_FULL) begin
               overflow <= 1'b1;
            end else begin
               cnt <= cnt + CNT_ONE;
            end
         end else if (bus.pop_i) begin
            if (empty) begin
               underflow <= 1'b1;
            end else begin
               tos <= tos - PTR_ONE;
               cnt <= cnt - CNT_ONE;
            end
         end
      end
   end

   ras_regfile #(
      .DEPTH (DEPTH),
      .AW    (PTR_W)
   ) u_regfile (
      .clk     (clk),
      .reset_n (reset_n),
      .we      (wr_en),
      .waddr   (wr_addr),
      .wdata   (bus.push_adr_i),
      .raddr   (tos),
      .rdata   (rd_data)
   );

   assign bus.tos_ptr_o    = tos;
   assign bus.count_o      = cnt;
   assign bus.pred_valid_o = !empty;
   assign bus.pred_adr_o   = empty ? kernel_adr : rd_data;
   assign bus.overflow_o   = overflow;
   assign bus.underflow_o  = underflow;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: directed scenarios plus random traffic, checked
// against a plain array/counter model of a circular return stack.
module tb_ret_addr_stack;

   localparam int D = 16;

   logic clk;
   logic reset_n;

   ret_addr_stack_if bus ();

   ret_addr_stack dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   // Entries live in a 16-slot ring; m_top indexes the newest valid entry,
   // m_cnt is how many of the newest entries are live (0..16).
   logic [31:0] m_mem [D];
   int          m_top;
   int          m_cnt;
   logic        m_ovf;
   logic        m_unf;

   // Expected post-edge view: {valid, adr[31:0], count[4:0], tos[3:0], ovf, unf}
   logic [43:0] exp_q [$];
   int          total;
   int          bad;

   function automatic logic [43:0] model_view();
      logic [31:0] adr;
      adr = (m_cnt != 0) ? m_mem[m_top] : 32'hF0000000;
      return {m_cnt != 0, adr, 5'(m_cnt), 4'(m_top), m_ovf, m_unf};
   endfunction

   task automatic model_step(input logic rst_n_v, input logic push, input logic pop,
                             input logic restore, input int rptr, input int rcnt,
                             input logic [31:0] adr);
      m_ovf = 1'b0;
      m_unf = 1'b0;
      if (!rst_n_v) begin
         for (int i = 0; i < D; i++) m_mem[i] = 32'h0;
         m_top = D - 1;
         m_cnt = 0;
      end else if (restore) begin
         m_top = rptr;
         m_cnt = rcnt;
      end else if (push && pop && m_cnt > 0) begin
         m_mem[m_top] = adr;
      end else if (push) begin
         m_top = (m_top + 1) % D;
         m_mem[m_top] = adr;
         if (m_cnt == D) m_ovf = 1'b1;
         else m_cnt = m_cnt + 1;
      end else if (pop) begin
         if (m_cnt == 0) begin
            m_unf = 1'b1;
         end else begin
            m_top = (m_top + D - 1) % D;
            m_cnt = m_cnt - 1;
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input logic rst_n_v, input logic push, input logic pop,
                       input logic restore, input int rptr, input int rcnt,
                       input logic [31:0] adr);
      @(negedge clk);
      reset_n           = rst_n_v;
      bus.push_i        = push;
      bus.pop_i         = pop;
      bus.restore_i     = restore;
      bus.restore_ptr_i = 4'(rptr);
      bus.restore_cnt_i = 5'(rcnt);
      bus.push_adr_i    = adr;
      model_step(rst_n_v, push, pop, restore, rptr, rcnt, adr);
      exp_q.push_back(model_view());
   endtask

   task automatic do_reset();             step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0); endtask
   task automatic do_idle();              step(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0); endtask
   task automatic do_push(input logic [31:0] a); step(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, a); endtask
   task automatic do_pop();               step(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0); endtask
   task automatic do_both(input logic [31:0] a); step(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, a); endtask
   task automatic do_restore(input int p, input int c, input logic push, input logic [31:0] a);
      step(1'b1, push, 1'b0, 1'b1, p, c, a);
   endtask

   // ---------------- scoreboard / monitor ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, got, want);
      end
   endtask

   initial begin
      logic [43:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pred_valid", 32'(bus.pred_valid_o), 32'(e[43]));
            check("pred_adr",   bus.pred_adr_o,        e[42:11]);
            check("count",      32'(bus.count_o),      32'(e[10:6]));
            check("tos_ptr",    32'(bus.tos_ptr_o),    32'(e[5:2]));
            check("overflow",   32'(bus.overflow_o),   32'(e[1]));
            check("underflow",  32'(bus.underflow_o),  32'(e[0]));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int r;
      int guard;
      total = 0;
      bad   = 0;
      reset_n = 1'b0;
      bus.push_i = 1'b0;
      bus.pop_i = 1'b0;
      bus.restore_i = 1'b0;
      bus.restore_ptr_i = '0;
      bus.restore_cnt_i = '0;
      bus.push_adr_i = '0;

      // Reset then idle.
      do_reset();
      do_idle();
      do_idle();

      // LIFO order of three pushes, then pops back to empty.
      do_push(32'h100);
      do_push(32'h200);
      do_push(32'h300);
      do_pop();
      do_pop();
      do_pop();
      do_idle();

      // Overflow on the 17th push, drain 16, then underflow.
      do_reset();
      for (int i = 0; i < 17; i++) do_push(32'hA000_0000 + 32'(i) * 32'h10);
      do_idle();
      for (int i = 0; i < 16; i++) do_pop();
      do_pop();
      do_idle();

      // Replace-top, and push+pop on an empty stack.
      do_reset();
      do_push(32'h40);
      do_both(32'h80);
      do_idle();
      do_pop();
      do_both(32'h90);
      do_idle();

      // Checkpoint / restore with a shadowed push.
      do_reset();
      do_push(32'h10);
      do_push(32'h20);
      do_push(32'h30);
      do_pop();
      do_pop();
      do_restore(1, 2, 1'b1, 32'hDEAD_BEEF);
      do_idle();

      // Reset with five live entries.
      for (int i = 0; i < 3; i++) do_push(32'h5000 + 32'(i));
      do_reset();
      do_idle();

      // Random traffic.
      for (int n = 0; n < 600; n++) begin
         r = $urandom_range(0, 99);
         if (r < 2) begin
            do_reset();
         end else if (r < 8) begin
            do_restore($urandom_range(0, D - 1), $urandom_range(0, D),
                       1'($urandom_range(0, 1)), $urandom);
         end else if (r < 50) begin
            do_push($urandom);
         end else if (r < 60) begin
            do_both($urandom);
         end else if (r < 92) begin
            do_pop();
         end else begin
            do_idle();
         end
      end
      do_idle();

      guard = 0;
      while (exp_q.size() != 0 && guard < 20) begin
         @(posedge clk);
         guard++;
      end
      #2;
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
